// File: rtl/branch_target_lut.sv
// branch_target_lut: run-time writable pointer-to-PC target table with self-initialising walker.
// Optional LUT_BYPASS_EN forwards same-edge write data to a same-address read.
module branch_target_lut #(
    parameter int ADDR_W = 2,
    parameter int WIDTH  = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [WIDTH-1:0]  Target,
    output logic              TargetValid,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [WIDTH-1:0]  WrData,
    output logic              Busy,
    output logic              WrErr
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [WIDTH-1:0]   target_q, target_d;
    logic               valid_q, valid_d;
    logic               wr_err_q, wr_err_d;

    function automatic logic [WIDTH-1:0] dflt(input logic [ADDR_W-1:0] i);
        return (i == '0) ? '1 : WIDTH'(i);
    endfunction

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        target_d = target_q;
        valid_d  = 1'b0;
        wr_err_d = 1'b0;
        if (state_q == INIT) begin
            mem_d[idx_q] = dflt(idx_q);
            idx_d        = idx_q + 1'b1;
            state_d      = (idx_q == ADDR_W'(DEPTH - 1)) ? RUN : INIT;
            wr_err_d     = WrEn;
        end else begin
            if (WrEn) mem_d[WrAddr] = WrData;
            if (RdEn) begin
`ifdef LUT_BYPASS_EN
                target_d = (WrEn && WrAddr == RdAddr) ? WrData : mem_q[RdAddr];
`else
                target_d = mem_q[RdAddr];
`endif
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= INIT;
            idx_q    <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Contents survive Reset; the INIT walk is what restores defaults.
    always_ff @(posedge Clk) begin
        if (!Reset) mem_q <= mem_d;
    end

    assign Target      = target_q;
    assign TargetValid = valid_q;
    assign Busy        = (state_q == INIT);
    assign WrErr       = wr_err_q;
endmodule

// File: doc/branch_target_lut.md
# branch_target_lut

Parametrised, run-time writable branch-target lookup table that expands a short pointer into a full-width PC target. It replaces the fixed 4-entry combinational target table in the fetch path. After reset it self-initialises through an internal walker FSM. It then serves registered reads and accepts writes from the control path, with an optional same-cycle write-to-read bypass.

## Interface
Parameters:
- ADDR_W, 2, pointer width; legal range 1..5, so at most 32 entries.
- WIDTH, 10, target width in bits.
- DEPTH (localparam), 2**ADDR_W, number of entries.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  reset, synchronous and active-high.
- RdEn  in  1  read request.
- RdAddr  in  ADDR_W  read pointer.
- Target  out  WIDTH  registered read data.
- TargetValid  out  1  Target holds data for the previous cycle's read.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_W  write pointer.
- WrData  in  WIDTH  write data.
- Busy  out  1  initialisation in progress.
- WrErr  out  1  one-cycle pulse when a write is dropped.

## Operation
- Storage: DEPTH x WIDTH register array, plus state register and ADDR_W-bit init index Idx.
- Default contents:
  - Entry 0 = all ones (-1).
  - Entry i >= 1 = i, zero-extended to WIDTH.
- FSM state INIT:
  - Each edge writes the default value into entry Idx, then increments Idx.
  - The edge that writes Idx == DEPTH-1 moves the FSM to RUN; Idx wraps to 0.
  - Busy = 1 throughout INIT.
  - RdEn is ignored and TargetValid = 0.
  - WrEn is dropped: WrErr = 1 on the following cycle and the array is unchanged.
- FSM state RUN:
  - Busy = 0. The FSM stays in RUN until Reset.
  - Write: WrEn = 1 updates entry WrAddr with WrData at the edge.
  - Read: RdEn = 1 loads Target with entry RdAddr and sets TargetValid = 1 at the edge.
  - RdEn = 0: Target holds its last value and TargetValid = 0.
- Simultaneous read and write, same address: behaviour depends on LUT_BYPASS_EN (see Configuration).
- Simultaneous read and write, different addresses: both complete independently.
- Reset:
  - Reset = 1 at any edge, including mid-INIT and mid-RUN, forces state INIT, Idx = 0, Target = 0, TargetValid = 0, WrErr = 0, Busy = 1.
  - Entry contents are not cleared by Reset itself; the INIT walk rewrites every entry.
  - Reset has priority over RdEn and WrEn.
- Reset values of outputs: Target = 0, TargetValid = 0, Busy = 1, WrErr = 0.

## Timing
- Read latency: 1 cycle. RdEn sampled at edge n gives Target and TargetValid valid after edge n.
- Write latency: 1 cycle. A write at edge n is visible to a read sampled at edge n+1.
- INIT duration: exactly DEPTH edges with Reset low.
  - The first edge with Reset low writes entry 0.
  - Busy falls after the edge that writes entry DEPTH-1 (4 edges for ADDR_W = 2, 32 edges for ADDR_W = 5).
  - The first accepted read or write is at the next edge.
- WrErr: registered and high for exactly one cycle per dropped write. Back-to-back dropped writes hold it high.
- No combinational path from any input to any output.

## Configuration
- LUT_BYPASS_EN defined:
  - A RUN-state read and write to the same address at the same edge returns WrData on Target. The array is also updated.
- LUT_BYPASS_EN undefined:
  - The same case returns the pre-write entry value.
  - The new value is visible from the next read onward.
- The macro has no effect on INIT behaviour, latency or reset values.

## Test plan
All scenarios use ADDR_W = 2, WIDTH = 10 unless noted.
- Reset, then 4 idle cycles, then read addresses 0..3 on consecutive cycles -> Busy falls after the 4th edge; Target = 0x3FF, 0x001, 0x002, 0x003 with TargetValid = 1 each cycle.
- In RUN, write 0x155 to address 2, then read address 2 next cycle -> Target = 0x155; a read of address 1 still returns 0x001.
- Same-edge read and write of address 3 with WrData = 0x2AA -> without LUT_BYPASS_EN, Target = 0x003 and the following read gives 0x2AA; with it, Target = 0x2AA immediately.
- WrEn and RdEn asserted during the INIT walk -> WrErr pulses one cycle per attempt, TargetValid stays 0, and post-init contents equal the defaults.
- Write 0x155 to address 2 in RUN, then assert Reset for 1 cycle mid-stream -> Busy = 1 and Target = 0 next cycle; after 4 more edges, address 2 reads 0x002.
- ADDR_W = 5, WIDTH = 16: reset, wait -> Busy low after exactly 32 edges; address 31 reads 0x001F and address 0 reads 0xFFFF.
